lsu_axi_port: RTL and testbench

LSU_AXI_PORT -- requirements
Module: lsu_axi_port

---
 rtl/lsu_axi_port_if.sv | 47 ++++
 rtl/lsu_axi_port.sv | 198 +++++++++++++++++++
 tb/tb_lsu_axi_port.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/lsu_axi_port_if.sv
// AXI4 single-beat channel bundle between the load/store unit (master) and memory (slave).
interface lsu_axi_port_if #(
  parameter int DataW  = 64,
  parameter int AxiIdW = 4
);
  logic [AxiIdW-1:0]  axi_awid;
  logic [31:0]        axi_awaddr;
  logic [2:0]         axi_awsize;
  logic               axi_awvalid;
  logic               axi_awready;
  logic [DataW-1:0]   axi_wdata;
  logic [DataW/8-1:0] axi_wstrb;
  logic               axi_wlast;
  logic               axi_wvalid;
  logic               axi_wready;
  logic [AxiIdW-1:0]  axi_bid;
  logic [1:0]         axi_bresp;
  logic               axi_bvalid;
  logic               axi_bready;
  logic [AxiIdW-1:0]  axi_arid;
  logic [31:0]        axi_araddr;
  logic [2:0]         axi_arsize;
  logic               axi_arvalid;
  logic               axi_arready;
  logic [AxiIdW-1:0]  axi_rid;
  logic [DataW-1:0]   axi_rdata;
  logic [1:0]         axi_rresp;
  logic               axi_rlast;
  logic               axi_rvalid;
  logic               axi_rready;

  modport master (
    output axi_awid, axi_awaddr, axi_awsize, axi_awvalid, input axi_awready,
    output axi_wdata, axi_wstrb, axi_wlast, axi_wvalid, input axi_wready,
    input  axi_bid, axi_bresp, axi_bvalid, output axi_bready,
    output axi_arid, axi_araddr, axi_arsize, axi_arvalid, input axi_arready,
    input  axi_rid, axi_rdata, axi_rresp, axi_rlast, axi_rvalid, output axi_rready
  );

  modport slave (
    input  axi_awid, axi_awaddr, axi_awsize, axi_awvalid, output axi_awready,
    input  axi_wdata, axi_wstrb, axi_wlast, axi_wvalid, output axi_wready,
    output axi_bid, axi_bresp, axi_bvalid, input axi_bready,
    input  axi_arid, axi_araddr, axi_arsize, axi_arvalid, output axi_arready,
    output axi_rid, axi_rdata, axi_rresp, axi_rlast, axi_rvalid, input axi_rready
  );
endinterface

// File: rtl/lsu_axi_port.sv
// Single-outstanding load/store port: one request at a time becomes one single-beat AXI
// read or write, with a registered one-cycle completion pulse.
module lsu_axi_port #(
  parameter int DataW  = 64,
  parameter int AxiIdW = 4,
  localparam int OffW  = $clog2(DataW / 8),
  localparam int StrbW = DataW / 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_store,
  input  logic        req_unsigned,
  input  logic [1:0]  req_size,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [4:0]  req_rd,
  output logic        resp_valid,
  output logic        resp_wen,
  output logic [4:0]  resp_rd,
  output logic [31:0] resp_data,
  output logic        resp_err,
  output logic        resp_misalign,
  output logic [2:0]  state_o,
  lsu_axi_port_if.master axi
);
  // Handshakes: a transfer happens on a rising edge where valid & ready are both 1;
  // a raised valid never drops and its payload never changes until that edge.
  typedef enum logic [2:0] {S_IDLE, S_AR, S_R, S_AWW, S_B, S_FLT} state_e;

  state_e            state_q, state_d;
  logic [AxiIdW-1:0] id_q, id_d, tid_q;
  logic              aw_pend_q, aw_pend_d, w_pend_q, w_pend_d;
  logic              unsigned_q;
  logic [1:0]        size_q;
  logic [31:0]       addr_q, wdata_q;
  logic [4:0]        rd_q;
  logic              lat_load;
  logic              misal, bus_err;
  logic [31:0]       lane, load_ext;
  logic [DataW-1:0]  wdata_rep;
  logic [StrbW-1:0]  strb_base;
  logic              resp_valid_d, resp_wen_d, resp_err_d, resp_mis_d;
  logic [31:0]       resp_data_d;
  logic              arvalid, rready, bready;
  logic              unused_sig;

  assign misal = (req_size == 2'd3) || (req_size == 2'd1 && req_addr[0]) ||
                 (req_size == 2'd2 && req_addr[1:0] != 2'b00);

  // Selected lane is shifted down to bit 0, then sized and extended.
  assign lane = 32'(axi.axi_rdata >> {addr_q[OffW-1:0], 3'b000});
  always_comb begin
    case (size_q)
      2'd0:    load_ext = {{24{~unsigned_q & lane[7]}}, lane[7:0]};
      2'd1:    load_ext = {{16{~unsigned_q & lane[15]}}, lane[15:0]};
      default: load_ext = lane;
    endcase
  end

  always_comb begin
    case (size_q)
      2'd0:    begin wdata_rep = {(DataW/8){wdata_q[7:0]}};   strb_base = StrbW'(4'h1); end
      2'd1:    begin wdata_rep = {(DataW/16){wdata_q[15:0]}}; strb_base = StrbW'(4'h3); end
      default: begin wdata_rep = {(DataW/32){wdata_q}};       strb_base = StrbW'(4'hF); end
    endcase
  end

  always_comb begin
    state_d      = state_q;
    id_d         = id_q;
    aw_pend_d    = aw_pend_q;
    w_pend_d     = w_pend_q;
    lat_load     = 1'b0;
    req_ready    = 1'b0;
    arvalid      = 1'b0;
    rready       = 1'b0;
    bready       = 1'b0;
    bus_err      = 1'b0;
    resp_valid_d = 1'b0;
    resp_wen_d   = 1'b0;
    resp_err_d   = 1'b0;
    resp_mis_d   = 1'b0;
    resp_data_d  = '0;
    case (state_q)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          lat_load = 1'b1;
          if (misal) begin
            state_d = S_FLT;
          end else if (req_store) begin
            state_d   = S_AWW;
            aw_pend_d = 1'b1;
            w_pend_d  = 1'b1;
            id_d      = id_q + 1'b1;
          end else begin
            state_d = S_AR;
            id_d    = id_q + 1'b1;
          end
        end
      end
      S_AR: begin
        arvalid = 1'b1;
        if (axi.axi_arready) state_d = S_R;
      end
      S_R: begin
        rready = 1'b1;
        if (axi.axi_rvalid) begin
          bus_err      = axi.axi_rresp[1] || (axi.axi_rid != tid_q);
          resp_valid_d = 1'b1;
          resp_err_d   = bus_err;
          resp_wen_d   = ~bus_err;
          resp_data_d  = bus_err ? 32'h0 : load_ext;
          state_d      = S_IDLE;
        end
      end
      S_AWW: begin
        if (aw_pend_q && axi.axi_awready) aw_pend_d = 1'b0;
        if (w_pend_q && axi.axi_wready)   w_pend_d  = 1'b0;
        if (!aw_pend_d && !w_pend_d)      state_d   = S_B;
      end
      S_B: begin
        bready = 1'b1;
        if (axi.axi_bvalid) begin
          resp_valid_d = 1'b1;
          resp_err_d   = axi.axi_bresp[1] || (axi.axi_bid != tid_q);
          state_d      = S_IDLE;
        end
      end
      S_FLT: begin
        resp_valid_d = 1'b1;
        resp_mis_d   = 1'b1;
        state_d      = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      id_q          <= '0;
      tid_q         <= '0;
      aw_pend_q     <= 1'b0;
      w_pend_q      <= 1'b0;
      unsigned_q    <= 1'b0;
      size_q        <= 2'd0;
      addr_q        <= '0;
      wdata_q       <= '0;
      rd_q          <= '0;
      resp_valid    <= 1'b0;
      resp_wen      <= 1'b0;
      resp_rd       <= '0;
      resp_data     <= '0;
      resp_err      <= 1'b0;
      resp_misalign <= 1'b0;
    end else begin
      state_q       <= state_d;
      id_q          <= id_d;
      aw_pend_q     <= aw_pend_d;
      w_pend_q      <= w_pend_d;
      if (lat_load) begin
        tid_q      <= id_q;
        unsigned_q <= req_unsigned;
        size_q     <= req_size;
        addr_q     <= req_addr;
        wdata_q    <= req_wdata;
        rd_q       <= req_rd;
      end
      resp_valid    <= resp_valid_d;
      resp_wen      <= resp_wen_d;
      resp_rd       <= resp_valid_d ? rd_q : 5'd0;
      resp_data     <= resp_data_d;
      resp_err      <= resp_err_d;
      resp_misalign <= resp_mis_d;
    end
  end

  assign state_o         = state_q;
  assign axi.axi_awid    = tid_q;
  assign axi.axi_awaddr  = addr_q;
  assign axi.axi_awsize  = {1'b0, size_q};
  assign axi.axi_awvalid = aw_pend_q;
  assign axi.axi_wdata   = wdata_rep;
  assign axi.axi_wstrb   = strb_base << addr_q[OffW-1:0];
  assign axi.axi_wlast   = 1'b1;
  assign axi.axi_wvalid  = w_pend_q;
  assign axi.axi_bready  = bready;
  assign axi.axi_arid    = tid_q;
  assign axi.axi_araddr  = addr_q;
  assign axi.axi_arsize  = {1'b0, size_q};
  assign axi.axi_arvalid = arvalid;
  assign axi.axi_rready  = rready;

  assign unused_sig = ^{axi.axi_rlast, axi.axi_rresp[0], axi.axi_bresp[0]};
endmodule

// File: tb/tb_lsu_axi_port.sv
// Directed bench for lsu_axi_port: loads, stores, faults, AXI stalls, errors and mid-transaction reset.
module tb_lsu_axi_port;
  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_store, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic [4:0]  req_rd;
  logic        resp_valid, resp_wen, resp_err, resp_misalign;
  logic [4:0]  resp_rd;
  logic [31:0] resp_data;
  logic [2:0]  state_o;
  int          checks = 0;
  int          errors = 0;

  lsu_axi_port_if #(.DataW(64), .AxiIdW(4)) axi ();

  lsu_axi_port #(.DataW(64), .AxiIdW(4)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
    .req_unsigned(req_unsigned), .req_size(req_size), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_rd(req_rd),
    .resp_valid(resp_valid), .resp_wen(resp_wen), .resp_rd(resp_rd),
    .resp_data(resp_data), .resp_err(resp_err), .resp_misalign(resp_misalign),
    .state_o(state_o), .axi(axi)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  // Advance one cycle; inputs are driven and outputs sampled at the falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic st, input logic uns, input logic [1:0] sz,
                       input logic [31:0] addr, input logic [31:0] wd, input logic [4:0] rd);
    req_valid = 1'b1; req_store = st; req_unsigned = uns; req_size = sz;
    req_addr = addr; req_wdata = wd; req_rd = rd;
    chk("req_ready_at_accept", req_ready, 1'b1);
    step();
    req_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_store = 1'b0; req_unsigned = 1'b0;
    req_size = 2'd0; req_addr = '0; req_wdata = '0; req_rd = '0;
    axi.axi_awready = 1'b1; axi.axi_wready = 1'b1;
    axi.axi_bid = '0; axi.axi_bresp = 2'd0; axi.axi_bvalid = 1'b0;
    axi.axi_arready = 1'b1; axi.axi_rid = '0; axi.axi_rdata = '0;
    axi.axi_rresp = 2'd0; axi.axi_rlast = 1'b1; axi.axi_rvalid = 1'b0;
    @(negedge clk);
    step();
    chk("rst_req_ready", req_ready, 1'b1);
    chk("rst_resp_valid", resp_valid, 1'b0);
    chk("rst_valids", {axi.axi_arvalid, axi.axi_awvalid, axi.axi_wvalid}, 3'b000);
    chk("rst_readys", {axi.axi_rready, axi.axi_bready}, 2'b00);
    chk("rst_state", state_o, 3'd0);
    rst = 1'b0;

    // Word load at 0x1004, zero-wait slave.
    axi.axi_rvalid = 1'b1; axi.axi_rid = 4'd0; axi.axi_rdata = 64'h11223344_AABBCCDD;
    issue(1'b0, 1'b0, 2'd2, 32'h1004, 32'h0, 5'd5);
    chk("ld_arvalid", axi.axi_arvalid, 1'b1);
    chk("ld_araddr", axi.axi_araddr, 32'h1004);
    chk("ld_arsize", axi.axi_arsize, 3'd2);
    chk("ld_arid", axi.axi_arid, 4'd0);
    chk("ld_req_ready_busy", req_ready, 1'b0);
    step();
    chk("ld_rready", axi.axi_rready, 1'b1);
    chk("ld_no_early_resp", resp_valid, 1'b0);
    step();
    chk("ld_resp_valid", resp_valid, 1'b1);
    chk("ld_resp_data", resp_data, 32'h11223344);
    chk("ld_resp_wen", resp_wen, 1'b1);
    chk("ld_resp_rd", resp_rd, 5'd5);
    chk("ld_resp_err", {resp_err, resp_misalign}, 2'b00);
    chk("ld_idle", req_ready, 1'b1);

    // Signed then unsigned byte load at 0x1003, lane 3 = 0x80; first issued in the resp cycle.
    axi.axi_rdata = 64'h00000000_80000000; axi.axi_rid = 4'd1;
    issue(1'b0, 1'b0, 2'd0, 32'h1003, 32'h0, 5'd6);
    chk("sb_resp_pulse_one_cycle", resp_valid, 1'b0);
    step(); step();
    chk("sb_resp_data", resp_data, 32'hFFFFFF80);
    axi.axi_rid = 4'd2;
    issue(1'b0, 1'b1, 2'd0, 32'h1003, 32'h0, 5'd7);
    step(); step();
    chk("ub_resp_data", resp_data, 32'h00000080);
    chk("ub_resp_wen", resp_wen, 1'b1);

    // Half store 0xBEEF at 0x2006, slave answers SLVERR.
    axi.axi_rvalid = 1'b0;
    axi.axi_bvalid = 1'b1; axi.axi_bresp = 2'd2; axi.axi_bid = 4'd3;
    issue(1'b1, 1'b0, 2'd1, 32'h2006, 32'h0000BEEF, 5'd8);
    chk("hs_valids", {axi.axi_awvalid, axi.axi_wvalid}, 2'b11);
    chk("hs_awsize", axi.axi_awsize, 3'd1);
    chk("hs_awaddr", axi.axi_awaddr, 32'h2006);
    chk("hs_awid", axi.axi_awid, 4'd3);
    chk("hs_wstrb", axi.axi_wstrb, 8'hC0);
    chk("hs_wdata", axi.axi_wdata, 64'hBEEFBEEF_BEEFBEEF);
    chk("hs_wlast", axi.axi_wlast, 1'b1);
    step();
    chk("hs_bready", axi.axi_bready, 1'b1);
    chk("hs_valids_dropped", {axi.axi_awvalid, axi.axi_wvalid}, 2'b00);
    step();
    chk("hs_resp_valid", resp_valid, 1'b1);
    chk("hs_resp_err", resp_err, 1'b1);
    chk("hs_resp_wen_data", {resp_wen, resp_data}, 33'h0);

    // Misaligned word load at 0x1002: no AXI activity, fault response after two cycles.
    axi.axi_bvalid = 1'b0;
    issue(1'b0, 1'b0, 2'd2, 32'h1002, 32'h0, 5'd9);
    chk("mis_state_flt", state_o, 3'd5);
    chk("mis_arvalid", axi.axi_arvalid, 1'b0);
    chk("mis_no_resp_yet", resp_valid, 1'b0);
    step();
    chk("mis_arvalid_after", axi.axi_arvalid, 1'b0);
    chk("mis_resp", {resp_valid, resp_misalign, resp_wen}, 3'b110);
    chk("mis_resp_data", resp_data, 32'h0);

    // Word store with wready immediate, awready held off three cycles (ID 4, fault consumed none).
    axi.axi_awready = 1'b0; axi.axi_wready = 1'b1;
    issue(1'b1, 1'b0, 2'd2, 32'h3000, 32'hCAFEF00D, 5'd10);
    chk("st_c1_valids", {axi.axi_awvalid, axi.axi_wvalid}, 2'b11);
    chk("st_wstrb", axi.axi_wstrb, 8'h0F);
    chk("st_wdata", axi.axi_wdata, 64'hCAFEF00D_CAFEF00D);
    chk("st_awid", axi.axi_awid, 4'd4);
    step();
    chk("st_c2_valids", {axi.axi_awvalid, axi.axi_wvalid}, 2'b10);
    step();
    chk("st_c3_valids", {axi.axi_awvalid, axi.axi_wvalid}, 2'b10);
    step();
    chk("st_c4_valids", {axi.axi_awvalid, axi.axi_wvalid}, 2'b10);
    chk("st_c4_bready", axi.axi_bready, 1'b0);
    axi.axi_awready = 1'b1;
    step();
    chk("st_in_b", {axi.axi_bready, axi.axi_awvalid}, 2'b10);
    axi.axi_bvalid = 1'b1; axi.axi_bresp = 2'd0; axi.axi_bid = 4'd4;
    step();
    chk("st_resp", {resp_valid, resp_err, resp_wen}, 3'b100);
    axi.axi_bvalid = 1'b0;

    // Load with wrong RID (expected ID 5).
    axi.axi_rvalid = 1'b1; axi.axi_rid = 4'hA; axi.axi_rdata = 64'h11223344_AABBCCDD;
    issue(1'b0, 1'b0, 2'd2, 32'h1000, 32'h0, 5'd11);
    chk("rid_arid", axi.axi_arid, 4'd5);
    step(); step();
    chk("rid_resp", {resp_valid, resp_err, resp_wen}, 3'b110);
    chk("rid_resp_data", resp_data, 32'h0);

    // Reset while waiting in R abandons the load and clears the ID counter.
    axi.axi_rvalid = 1'b0;
    issue(1'b0, 1'b0, 2'd2, 32'h1000, 32'h0, 5'd12);
    step();
    chk("rr_in_r", axi.axi_rready, 1'b1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rr_req_ready", req_ready, 1'b1);
    chk("rr_rready", axi.axi_rready, 1'b0);
    chk("rr_no_resp", resp_valid, 1'b0);
    axi.axi_rvalid = 1'b1;
    step();
    chk("rr_no_resp_later", resp_valid, 1'b0);
    axi.axi_rid = 4'd0; axi.axi_rdata = 64'h0000_0000_0000_1234;
    issue(1'b0, 1'b1, 2'd1, 32'h1000, 32'h0, 5'd13);
    chk("rr_arid_zero", axi.axi_arid, 4'd0);
    step(); step();
    chk("rr_half_resp", {resp_valid, resp_err, resp_data}, {2'b10, 32'h00001234});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
